// File: rtl/imc_array_sequencer_pkg.sv
// Shared types for the IMC array sequencer: op codes, FSM states, latched command,
// analog drive bundle and default phase lengths.
package imc_seq_pkg;
   localparam int MEM_ROW        = 16;
   localparam int SRAM_OUT_WIDTH = 16;
   localparam int IMC_OUT_WIDTH  = 64;
   localparam int CNT_W          = 4;
   localparam int ROW_IDX_W      = $clog2(MEM_ROW);

   localparam logic [CNT_W-1:0] T_PRE = 4'd2;
   localparam logic [CNT_W-1:0] T_WL  = 4'd2;
   localparam logic [CNT_W-1:0] T_SA  = 4'd1;

   typedef enum logic [1:0] {
      OP_WR  = 2'b00,
      OP_RD  = 2'b01,
      OP_IMC = 2'b10,
      OP_RSV = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRECH,
      ST_WRITE,
      ST_WLACT,
      ST_SENSE,
      ST_RESP
   } state_t;

   typedef struct packed {
      op_t                  op;
      logic [ROW_IDX_W-1:0] row;
      logic [MEM_ROW-1:0]   din;
      logic [MEM_ROW-1:0]   vec;
      logic [CNT_W-1:0]     t_wl;
      logic [CNT_W-1:0]     t_sa;
   } cmd_t;

   typedef struct packed {
      logic               pre_sram;
      logic               we;
      logic               pre_vlsa;
      logic               pre_clsa;
      logic               pre_a;
      logic               saen;
      logic               en_vclp;
      logic [MEM_ROW-1:0] wwl;
      logic [MEM_ROW-1:0] rwl;
      logic [MEM_ROW-1:0] rwlb;
      logic [MEM_ROW-1:0] din;
   } ana_t;

   // Timer reload value for a phase of d cycles; a zero length runs as one cycle.
   function automatic logic [CNT_W-1:0] dur_load(input logic [CNT_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction
endpackage

// File: rtl/imc_array_sequencer_if.sv
// Command/response handshake and analog macro signals of imc_array_sequencer.
// PULSE_CFG_EN adds the per-command phase length inputs cfg_t_pre/cfg_t_wl/cfg_t_sa.
interface imc_array_sequencer_if #(
   parameter int ROW_W = imc_seq_pkg::ROW_IDX_W
);
   logic                                   cmd_valid;
   logic                                   cmd_ready;
   logic [1:0]                             cmd_op;
   logic [ROW_W-1:0]                       cmd_row;
   logic [imc_seq_pkg::MEM_ROW-1:0]        cmd_din;
   logic [imc_seq_pkg::MEM_ROW-1:0]        cmd_vec;
`ifdef PULSE_CFG_EN
   logic [imc_seq_pkg::CNT_W-1:0]          cfg_t_pre;
   logic [imc_seq_pkg::CNT_W-1:0]          cfg_t_wl;
   logic [imc_seq_pkg::CNT_W-1:0]          cfg_t_sa;
`endif
   logic                                   rsp_valid;
   logic                                   rsp_ready;
   logic [imc_seq_pkg::IMC_OUT_WIDTH-1:0]  rsp_data;
   logic                                   rsp_err;
   logic PRE_SRAM, WE, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, EN_VCLP;
   logic [imc_seq_pkg::MEM_ROW-1:0]        WWL, RWL, RWLB, SRAM_Din;
   logic [imc_seq_pkg::SRAM_OUT_WIDTH-1:0] SA_out;
   logic [imc_seq_pkg::IMC_OUT_WIDTH-1:0]  IMC_out;

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_din, cmd_vec,
`ifdef PULSE_CFG_EN
      output cfg_t_pre, cfg_t_wl, cfg_t_sa,
`endif
      output rsp_ready, SA_out, IMC_out,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
      input  PRE_SRAM, WE, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, EN_VCLP,
      input  WWL, RWL, RWLB, SRAM_Din
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_din, cmd_vec,
`ifdef PULSE_CFG_EN
      input  cfg_t_pre, cfg_t_wl, cfg_t_sa,
`endif
      input  rsp_ready, SA_out, IMC_out,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
      output PRE_SRAM, WE, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, EN_VCLP,
      output WWL, RWL, RWLB, SRAM_Din
   );
endinterface

// File: rtl/imc_array_sequencer_pulse_timer.sv
// Loadable down-counter timing one sequencer phase; o_done marks the phase's last cycle.
module imc_pulse_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_done
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)           r_cnt <= '0;
      else if (i_load)        r_cnt <= i_val;
      else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
   end

   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/imc_array_sequencer.sv
// Phase sequencer for the 16x16 SRAM/IMC macro: precharge, wordline, write and sense phases
// with registered analog drives. PULSE_CFG_EN selects per-command phase lengths.
module imc_array_sequencer
   import imc_seq_pkg::*;
#(
   parameter int ROW_W = ROW_IDX_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   imc_array_sequencer_if.slave bus
);
   state_t                   r_state;
   cmd_t                     r_cmd;
   ana_t                     r_ana;
   logic                     r_rsp_valid;
   logic                     r_rsp_err;
   logic [IMC_OUT_WIDTH-1:0] r_rsp_data;
   logic                     w_done, w_load, w_err;
   logic [CNT_W-1:0]         w_load_val, w_t_pre, w_t_wl, w_t_sa;
   logic [MEM_ROW-1:0]       w_row_oh;

`ifdef PULSE_CFG_EN
   assign w_t_pre = bus.cfg_t_pre;
   assign w_t_wl  = bus.cfg_t_wl;
   assign w_t_sa  = bus.cfg_t_sa;
`else
   assign w_t_pre = T_PRE;
   assign w_t_wl  = T_WL;
   assign w_t_sa  = T_SA;
`endif

   // Row is checked at full port width so out-of-range rows never alias into the array.
   assign w_err    = (bus.cmd_op == OP_RSV) || (32'(bus.cmd_row) >= MEM_ROW);
   assign w_row_oh = {{(MEM_ROW-1){1'b0}}, 1'b1} << r_cmd.row;

   function automatic ana_t ana_prech(input op_t op);
      ana_t a;
      a          = '0;
      a.pre_sram = 1'b1;
      a.pre_vlsa = (op == OP_RD);
      a.pre_clsa = (op == OP_IMC);
      a.pre_a    = (op == OP_IMC);
      a.en_vclp  = (op == OP_IMC);
      return a;
   endfunction

   function automatic ana_t ana_write(input cmd_t c, input logic [MEM_ROW-1:0] oh);
      ana_t a;
      a     = '0;
      a.wwl = oh;
      a.we  = 1'b1;
      a.din = c.din;
      return a;
   endfunction

   function automatic ana_t ana_wlact(input cmd_t c, input logic [MEM_ROW-1:0] oh);
      ana_t a;
      a = '0;
      if (c.op == OP_IMC) begin
         a.rwl     = c.vec;
         a.rwlb    = ~c.vec;
         a.en_vclp = 1'b1;
      end else begin
         a.rwl = oh;
      end
      return a;
   endfunction

   // The single timer is reloaded on the cycle a phase ends, ready for the next phase.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         ST_IDLE: if (bus.cmd_valid && !w_err) begin
            w_load     = 1'b1;
            w_load_val = dur_load(w_t_pre);
         end
         ST_PRECH: if (w_done) begin
            w_load     = 1'b1;
            w_load_val = dur_load(r_cmd.t_wl);
         end
         ST_WLACT: if (w_done) begin
            w_load     = 1'b1;
            w_load_val = dur_load(r_cmd.t_sa);
         end
         default: ;
      endcase
   end

   imc_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_load),
      .i_val   (w_load_val),
      .o_done  (w_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cmd       <= '0;
         r_ana       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.cmd_valid) begin
               r_cmd <= '{op:   op_t'(bus.cmd_op),
                          row:  bus.cmd_row[ROW_IDX_W-1:0],
                          din:  bus.cmd_din,
                          vec:  bus.cmd_vec,
                          t_wl: w_t_wl,
                          t_sa: w_t_sa};
               if (w_err) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= '0;
               end else begin
                  r_state <= ST_PRECH;
                  r_ana   <= ana_prech(op_t'(bus.cmd_op));
               end
            end
            ST_PRECH: if (w_done) begin
               if (r_cmd.op == OP_WR) begin
                  r_state <= ST_WRITE;
                  r_ana   <= ana_write(r_cmd, w_row_oh);
               end else begin
                  r_state <= ST_WLACT;
                  r_ana   <= ana_wlact(r_cmd, w_row_oh);
               end
            end
            ST_WRITE: if (w_done) begin
               r_state     <= ST_RESP;
               r_ana       <= '0;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= '0;
            end
            ST_WLACT: if (w_done) begin
               r_state    <= ST_SENSE;
               r_ana.saen <= 1'b1;
            end
            ST_SENSE: if (w_done) begin
               r_state     <= ST_RESP;
               r_ana       <= '0;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= (r_cmd.op == OP_IMC) ? bus.IMC_out :
                              {{(IMC_OUT_WIDTH-SRAM_OUT_WIDTH){1'b0}}, bus.SA_out};
            end
            ST_RESP: if (bus.rsp_ready) begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (r_state == ST_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.PRE_SRAM  = r_ana.pre_sram;
   assign bus.WE        = r_ana.we;
   assign bus.PRE_VLSA  = r_ana.pre_vlsa;
   assign bus.PRE_CLSA  = r_ana.pre_clsa;
   assign bus.PRE_A     = r_ana.pre_a;
   assign bus.SAEN      = r_ana.saen;
   assign bus.EN_VCLP   = r_ana.en_vclp;
   assign bus.WWL       = r_ana.wwl;
   assign bus.RWL       = r_ana.rwl;
   assign bus.RWLB      = r_ana.rwlb;
   assign bus.SRAM_Din  = r_ana.din;
endmodule

// File: tb/tb_imc_array_sequencer.sv
// Self-checking bench for imc_array_sequencer: directed and random commands against a
// phase-arithmetic reference model; PULSE_CFG_EN builds also exercise configurable lengths.
module tb_imc_array_sequencer;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk = 0;
   int   n_fail = 0;

   imc_array_sequencer_if #(.ROW_W(5)) bus ();
   imc_array_sequencer #(.ROW_W(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   logic [70:0] obs_ana;
   assign obs_ana = {bus.PRE_SRAM, bus.WE, bus.PRE_VLSA, bus.PRE_CLSA, bus.PRE_A, bus.SAEN,
                     bus.EN_VCLP, bus.WWL, bus.RWL, bus.RWLB, bus.SRAM_Din};

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   // Expected analog drives in cycle k after accept, from the phase lengths p/w/s.
   function automatic logic [70:0] model_ana(input logic [1:0] op, input int row,
                                             input logic [15:0] din, input logic [15:0] vec,
                                             input int p, input int w, input int s, input int k);
      logic ps, we, pv, pc, pa, sa, en;
      logic [15:0] wwl, rwl, rwlb, d, oh;
      ps = 0; we = 0; pv = 0; pc = 0; pa = 0; sa = 0; en = 0;
      wwl = '0; rwl = '0; rwlb = '0; d = '0;
      oh = 16'(1) << row;
      if (op == 2'd3 || row >= 16) begin
      end else if (k >= 1 && k <= p) begin
         ps = 1; pv = (op == 2'd1); pc = (op == 2'd2); pa = pc; en = pc;
      end else if (k > p && k <= p + w + ((op == 2'd0) ? 0 : s)) begin
         if (op == 2'd0) begin wwl = oh; we = 1; d = din; end
         else if (op == 2'd1) rwl = oh;
         else begin rwl = vec; rwlb = ~vec; en = 1; end
         sa = (op != 2'd0) && (k > p + w);
      end
      return {ps, we, pv, pc, pa, sa, en, wwl, rwl, rwlb, d};
   endfunction

   function automatic logic [63:0] model_data(input logic [1:0] op, input int row,
                                              input logic [15:0] sa, input logic [63:0] imc);
      if (op == 2'd3 || row >= 16 || op == 2'd0) return 64'h0;
      if (op == 2'd1) return {48'h0, sa};
      return imc;
   endfunction

   task automatic test_txn(input string tag, input logic [1:0] op, input int row,
                           input logic [15:0] din, input logic [15:0] vec, input logic [15:0] sa,
                           input logic [63:0] imc, input int cp, input int cw, input int cs,
                           input int hold, input bit early);
      int p, w, s, len;
      bit err;
      logic [63:0] exp_d;
      logic [70:0] exp_a;
      err = (op == 2'd3) || (row >= 16);
`ifdef PULSE_CFG_EN
      p = eff(cp); w = eff(cw); s = eff(cs);
`else
      p = 2; w = 2; s = 1;
`endif
      len   = err ? 1 : (op == 2'd0) ? p + w + 1 : p + w + s + 1;
      exp_d = model_data(op, row, sa, imc);
      @(negedge clk);
      n_chk++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s cmd_ready before accept: got %b want 1", tag, bus.cmd_ready);
      end
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_row = 5'(row);
      bus.cmd_din = din; bus.cmd_vec = vec;
      bus.SA_out = ~sa; bus.IMC_out = ~imc; bus.rsp_ready = early;
`ifdef PULSE_CFG_EN
      bus.cfg_t_pre = 4'(cp); bus.cfg_t_wl = 4'(cw); bus.cfg_t_sa = 4'(cs);
`endif
      @(posedge clk); #1;
      // Source keeps a (garbage) command valid while busy; it must be ignored.
      bus.cmd_op = 2'($urandom); bus.cmd_row = 5'($urandom);
      bus.cmd_din = 16'($urandom); bus.cmd_vec = 16'($urandom);
`ifdef PULSE_CFG_EN
      bus.cfg_t_pre = 4'($urandom); bus.cfg_t_wl = 4'($urandom); bus.cfg_t_sa = 4'($urandom);
`endif
      for (int k = 1; k < len; k++) begin
         @(negedge clk);
         exp_a = model_ana(op, row, din, vec, p, w, s, k);
         n_chk++;
         if (obs_ana !== exp_a || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s phase k=%0d: ana got %h want %h, rsp_valid=%b cmd_ready=%b want 0/0",
                     tag, k, obs_ana, exp_a, bus.rsp_valid, bus.cmd_ready);
         end
         if (k == p + w + s - 1) begin bus.SA_out = sa; bus.IMC_out = imc; end
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_chk++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== err || bus.rsp_data !== exp_d ||
          obs_ana !== '0 || bus.cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s response k=%0d: valid=%b err=%b data=%h ana=%h ready=%b want 1/%b/%h/0/0",
                  tag, len, bus.rsp_valid, bus.rsp_err, bus.rsp_data, obs_ana, bus.cmd_ready,
                  err, exp_d);
      end
      bus.rsp_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         bus.SA_out = 16'($urandom); bus.IMC_out = {$urandom, $urandom};
         @(negedge clk);
         n_chk++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== err || bus.rsp_data !== exp_d ||
             obs_ana !== '0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold h=%0d: valid=%b err=%b data=%h ready=%b want 1/%b/%h/0",
                     tag, h, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.cmd_ready, err, exp_d);
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      n_chk++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || obs_ana !== '0) begin
         n_fail++;
         $display("FAIL %s after consume: valid=%b ready=%b ana=%h want 0/1/0",
                  tag, bus.rsp_valid, bus.cmd_ready, obs_ana);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_row = 0; bus.cmd_din = 0; bus.cmd_vec = 0;
      bus.rsp_ready = 0; bus.SA_out = 0; bus.IMC_out = 0;
`ifdef PULSE_CFG_EN
      bus.cfg_t_pre = 4'd2; bus.cfg_t_wl = 4'd2; bus.cfg_t_sa = 4'd1;
`endif
      #23;
      n_chk++;
      if (obs_ana !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
          bus.rsp_data !== 64'h0 || bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: ana=%h valid=%b err=%b data=%h ready=%b want 0/0/0/0/1",
                  obs_ana, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.cmd_ready);
      end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs_ana !== '0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: ana=%h valid=%b ready=%b want 0/0/1",
                  obs_ana, bus.rsp_valid, bus.cmd_ready);
      end
   endtask

   task automatic test_write();
      test_txn("write_r3", 2'd0, 3, 16'hA5A5, 16'h0, 16'h0, 64'h0, 2, 2, 1, 0, 0);
      test_txn("write_r0", 2'd0, 0, 16'h5A3C, 16'h0, 16'h0, 64'h0, 2, 2, 1, 1, 0);
   endtask

   task automatic test_read();
      test_txn("read_r15", 2'd1, 15, 16'h0, 16'h0, 16'h1234, 64'h0, 2, 2, 1, 0, 0);
   endtask

   task automatic test_imc();
      test_txn("imc_00ff", 2'd2, 0, 16'h0, 16'h00FF, 16'h0, 64'hFEDC_BA98_7654_3210, 2, 2, 1, 0, 1);
   endtask

   task automatic test_error();
      test_txn("err_op3", 2'd3, 2, 16'hFFFF, 16'hFFFF, 16'h0, 64'h0, 2, 2, 1, 0, 0);
      test_txn("err_row16", 2'd0, 16, 16'hFFFF, 16'h0, 16'h0, 64'h0, 2, 2, 1, 0, 0);
      test_txn("err_row31_rd", 2'd1, 31, 16'h0, 16'h0, 16'hBEEF, 64'h0, 2, 2, 1, 2, 0);
   endtask

   task automatic test_backpressure();
      test_txn("bp_read", 2'd1, 5, 16'h0, 16'h0, 16'hC0DE, 64'h0, 2, 2, 1, 10, 0);
      test_txn("bp_imc", 2'd2, 0, 16'h0, 16'hA0F1, 16'h0, 64'h0123_4567_89AB_CDEF, 2, 2, 1, 3, 0);
   endtask

   task automatic test_reset_midop();
      logic [70:0] exp_a;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_row = 5'd7;
`ifdef PULSE_CFG_EN
      bus.cfg_t_pre = 4'd2; bus.cfg_t_wl = 4'd2; bus.cfg_t_sa = 4'd1;
`endif
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp_a = model_ana(2'd1, 7, 16'h0, 16'h0, 2, 2, 1, k);
         n_chk++;
         if (obs_ana !== exp_a) begin
            n_fail++;
            $display("FAIL midop_pre k=%0d: ana got %h want %h", k, obs_ana, exp_a);
         end
      end
      #2 reset_n = 1'b0;
      #1;
      n_chk++;
      if (obs_ana !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
          bus.rsp_data !== 64'h0 || bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_reset: ana=%h valid=%b err=%b data=%h ready=%b want 0/0/0/0/1",
                  obs_ana, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.cmd_ready);
      end
      @(negedge clk); reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_chk++;
         if (obs_ana !== '0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_after k=%0d: ana=%h valid=%b ready=%b want 0/0/1",
                     k, obs_ana, bus.rsp_valid, bus.cmd_ready);
         end
      end
   endtask

`ifdef PULSE_CFG_EN
   task automatic test_cfg();
      test_txn("cfg431_rd", 2'd1, 9, 16'h0, 16'h0, 16'h7E57, 64'h0, 4, 1, 3, 0, 0);
      test_txn("cfg431_imc", 2'd2, 0, 16'h0, 16'h3C5A, 16'h0, 64'hDEAD_BEEF_0BAD_F00D, 4, 1, 3, 1, 0);
      test_txn("cfg000_rd", 2'd1, 2, 16'h0, 16'h0, 16'h0F0F, 64'h0, 0, 0, 0, 0, 0);
      test_txn("cfg000_wr", 2'd0, 12, 16'h1357, 16'h0, 16'h0, 64'h0, 0, 0, 0, 0, 1);
   endtask
`endif

   task automatic test_random();
      int r, row;
      logic [1:0] op;
      for (int i = 0; i < 40; i++) begin
         r   = $urandom_range(0, 9);
         op  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         row = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
         test_txn($sformatf("rand%0d", i), op, row, 16'($urandom), 16'($urandom), 16'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_imc();
      test_error();
      test_backpressure();
      test_reset_midop();
`ifdef PULSE_CFG_EN
      test_cfg();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
